reg_write_scoreboard: RTL

Destination-register scoreboard for the 5-stage pipeline. On every instruction issued out of decode it decodes which register (if any) the instruction will write and records a pending write. On every writeback it retires that pending write. It raises `stall` when the instruction in decode reads a register with an outstanding write. It is the write-side counterpart to the decode-stage source-register count used by hazard detection, and sits beside the decode/hazard unit.

---
 rtl/reg_write_scoreboard.sv | 127 ++++++++++++
 1 files changed

// File: rtl/reg_write_scoreboard.sv
// rtl/reg_write_scoreboard.sv - destination-register pending-write scoreboard with issue stall
// Tracks outstanding writes per register and stalls decode on read-after-write or counter saturation.
module reg_write_scoreboard #(
    parameter int CNT_W = 2
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_id_valid,
    input  logic [15:0] i_id_instr,
    output logic        o_issue,
    output logic        o_stall,
    input  logic        i_wb_valid,
    input  logic [2:0]  i_wb_reg,
    input  logic        i_flush,
    output logic [7:0]  o_pending,
    output logic        o_err
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] r_cnt [8];
    logic             r_err;

    logic [4:0] w_op;
    logic [2:0] w_rs;
    logic [2:0] w_rt;
    logic [2:0] w_rd;
    logic       w_has_dst;
    logic [2:0] w_dst;
    logic       w_use_rs;
    logic       w_use_rt;
    logic       w_src_busy;
    logic       w_dst_full;
    logic [7:0] w_inc;
    logic [7:0] w_dec;

    assign w_op = i_id_instr[15:11];
    assign w_rs = i_id_instr[10:8];
    assign w_rt = i_id_instr[7:5];
    assign w_rd = i_id_instr[4:2];

    always_comb begin
        w_has_dst = 1'b0;
        w_dst     = 3'd0;
        w_use_rs  = 1'b0;
        w_use_rt  = 1'b0;
        case (w_op)
            5'b11001: begin
                w_has_dst = 1'b1; w_dst = w_rd; w_use_rs = 1'b1;
            end
            5'b11011, 5'b11010, 5'b11100, 5'b11101, 5'b11110, 5'b11111: begin
                w_has_dst = 1'b1; w_dst = w_rd; w_use_rs = 1'b1; w_use_rt = 1'b1;
            end
            5'b01000, 5'b01001, 5'b01010, 5'b01011,
            5'b10100, 5'b10101, 5'b10110, 5'b10111, 5'b10001: begin
                w_has_dst = 1'b1; w_dst = w_rt; w_use_rs = 1'b1;
            end
            5'b11000: begin
                w_has_dst = 1'b1; w_dst = w_rs;
            end
            5'b10010: begin
                w_has_dst = 1'b1; w_dst = w_rs; w_use_rs = 1'b1;
            end
            // STU writes back the updated base register it also reads
            5'b10011: begin
                w_has_dst = 1'b1; w_dst = w_rs; w_use_rs = 1'b1; w_use_rt = 1'b1;
            end
            5'b10000: begin
                w_use_rs = 1'b1; w_use_rt = 1'b1;
            end
            5'b00110: begin
                w_has_dst = 1'b1; w_dst = 3'd7;
            end
            5'b00111: begin
                w_has_dst = 1'b1; w_dst = 3'd7; w_use_rs = 1'b1;
            end
            5'b00101, 5'b01100, 5'b01101, 5'b01110, 5'b01111: begin
                w_use_rs = 1'b1;
            end
            default: begin
                w_has_dst = 1'b0;
            end
        endcase
    end

    // No writeback bypass: hazards are judged on registered counters only
    assign w_src_busy = (w_use_rs && (r_cnt[w_rs] != '0)) ||
                        (w_use_rt && (r_cnt[w_rt] != '0));
    assign w_dst_full = w_has_dst && (r_cnt[w_dst] == CNT_MAX);
    assign o_stall    = i_id_valid && (w_src_busy || w_dst_full);
    assign o_issue    = i_id_valid && !o_stall;
    assign o_err      = r_err;

    always_comb begin
        w_inc     = '0;
        w_dec     = '0;
        o_pending = '0;
        for (int r = 0; r < 8; r++) begin
            w_inc[r]     = o_issue && w_has_dst && (w_dst == 3'(r));
            w_dec[r]     = i_wb_valid && (i_wb_reg == 3'(r)) && (r_cnt[r] != '0);
            o_pending[r] = (r_cnt[r] != '0);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int r = 0; r < 8; r++) begin
                r_cnt[r] <= '0;
            end
            r_err <= 1'b0;
        end else if (i_flush) begin
            for (int r = 0; r < 8; r++) begin
                r_cnt[r] <= '0;
            end
        end else begin
            if (i_wb_valid && (r_cnt[i_wb_reg] == '0)) begin
                r_err <= 1'b1;
            end
            for (int r = 0; r < 8; r++) begin
                if (w_inc[r] && !w_dec[r]) begin
                    r_cnt[r] <= r_cnt[r] + CNT_W'(1);
                end else if (w_dec[r] && !w_inc[r]) begin
                    r_cnt[r] <= r_cnt[r] - CNT_W'(1);
                end
            end
        end
    end
endmodule
